flow_8_csum: RTL
================

Name: flow_8_csum

Overview:
Downstream neighbour of the 16-to-8 flow converter. It consumes the 8-bit valid-ready byte stream and groups it into fixed-length packets of PKT_LEN data bytes. After each packet it appends one two's-complement checksum byte, flagged with dst_last. The output side is also 8-bit valid-ready and feeds the byte-serial transmit logic.

Parameters:
PKT_LEN, 4, data bytes per packet; legal range 1..255.
CNT_W, 8, width of the internal byte counter; must hold PKT_LEN-1.

Ports:
clk  input  1  clock; all logic synchronous on rising edge
rst  input  1  reset; synchronous, active-high
cfg_en  input  1  enable, active high; protocol may be violated on disable
src_val  input  1  input byte valid
src_rdy  output  1  input byte ready
src_data  input  8  input byte; steady while src_val
dst_val  output  1  output byte valid
dst_rdy  input  1  output byte ready
dst_data  output  8  output byte; steady while dst_val and not dst_rdy
dst_last  output  1  high with dst_val on the checksum byte only
pkt_cnt  output  16  count of checksum bytes accepted downstream; wraps at 16'hFFFF->0

Behaviour:
- Reset (rst=1 at posedge): state=DATA, byte_cnt=0, csum=0, dst_val=0, dst_last=0, dst_data=0, pkt_cnt=0.
- Output slot free: slot_free = ~dst_val | dst_rdy.
- Input handshake: src_rdy = cfg_en & (state==DATA) & slot_free. This is combinational from dst_rdy; no register in that path.
- Input accepted: acc = src_val & src_rdy.
- State DATA, on acc:
  - dst_data<=src_data, dst_val<=1, dst_last<=0.
  - csum<=csum+src_data, mod 256 (8-bit wrap, carry dropped).
  - If byte_cnt==PKT_LEN-1: byte_cnt<=0 and state<=CSUM. Otherwise byte_cnt<=byte_cnt+1.
- State DATA, no acc: if dst_rdy & dst_val, then dst_val<=0; all else holds.
- State CSUM:
  - src_rdy=0.
  - When slot_free: dst_data<=(~csum)+1 (8-bit), dst_val<=1, dst_last<=1, csum<=0, state<=DATA.
  - Otherwise hold.
- Checksum property: the 8-bit sum of all PKT_LEN data bytes plus the checksum byte is 0.
- pkt_cnt increments on dst_val & dst_rdy & dst_last.
- Latency: input byte appears on dst one cycle after acc.
- Throughput: with dst_rdy held high, a packet takes PKT_LEN+1 cycles (one bubble per packet on src_rdy).
- Backpressure: while dst_val & ~dst_rdy, dst_data and dst_last hold, and src_rdy=0.
- Simultaneous events:
  - In DATA, acc with dst_rdy high replaces the outgoing byte in the same edge; no bubble.
  - In CSUM, the checksum is loaded in the same edge the last data byte is taken downstream.
- PKT_LEN=1: every data byte is followed by its checksum, which equals the negated byte.
- cfg_en=0 (synchronous, checked after rst):
  - Clears state, byte_cnt, csum, dst_val, dst_last and dst_data to 0.
  - pkt_cnt holds.
  - src_rdy=0.
  - A partial packet is discarded. On re-enable the next byte starts a new packet.
- rst mid-packet: same as the reset values; pkt_cnt is also cleared.

Test Plan:
- PKT_LEN=4, dst_rdy=1, bytes 01 02 03 04 -> dst shows 01 02 03 04 F6; dst_last only on F6; pkt_cnt=1; src_rdy low exactly 1 cycle after the 04 accept.
- Wrap arithmetic: bytes FF FF FF FF -> checksum 04. Bytes 80 80 00 00 -> checksum 00 with dst_last=1.
- Backpressure: dst_rdy=0 for 3 cycles while 02 is on dst -> dst_data stays 02, src_rdy=0, no byte lost or duplicated; final checksum still F6.
- Back-to-back packets: 8 bytes 01..08 with src_val always 1 -> outputs 01 02 03 04 F6 05 06 07 08 E6; pkt_cnt=2 after 10 output beats.
- cfg_en drop after 2 bytes of a packet -> dst_val=0 next cycle, pkt_cnt unchanged. After re-enable, bytes 10 20 30 40 -> checksum 60.
- PKT_LEN=1 build, bytes 05 then 00 -> outputs 05 FB 00 00; dst_last on the 2nd and 4th beats. rst asserted mid-stream -> all outputs 0 and pkt_cnt=0 the next cycle.

Source files
------------

// File: rtl/flow_8_csum.sv
// flow_8_csum: groups an 8-bit valid/ready byte stream into PKT_LEN-byte
// packets and appends a two's-complement checksum byte (flagged dst_last)
// after each packet. Counts delivered checksum bytes in pkt_cnt.
module flow_8_csum #(
    parameter int unsigned PKT_LEN = 4,
    parameter int unsigned CNT_W   = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cfg_en,
    input  logic        src_val,
    output logic        src_rdy,
    input  logic [7:0]  src_data,
    output logic        dst_val,
    input  logic        dst_rdy,
    output logic [7:0]  dst_data,
    output logic        dst_last,
    output logic [15:0] pkt_cnt
);

    typedef enum logic {
        ST_DATA = 1'b0,
        ST_CSUM = 1'b1
    } state_t;

    state_t             state_q,    state_d;
    logic [CNT_W-1:0]   byte_cnt_q, byte_cnt_d;
    logic [7:0]         csum_q,     csum_d;
    logic               dst_val_q,  dst_val_d;
    logic               dst_last_q, dst_last_d;
    logic [7:0]         dst_data_q, dst_data_d;
    logic [15:0]        pkt_cnt_q,  pkt_cnt_d;

    logic slot_free;
    logic acc;

    // Handshake: the output slot frees up in the same cycle it is drained,
    // so src_rdy is combinational from dst_rdy.
    always_comb begin
        slot_free = ~dst_val_q | dst_rdy;
        src_rdy   = cfg_en & (state_q == ST_DATA) & slot_free;
        acc       = src_val & src_rdy;
    end

    // Next-state: data pass-through, checksum insertion, disable clear.
    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        csum_d     = csum_q;
        dst_val_d  = dst_val_q;
        dst_last_d = dst_last_q;
        dst_data_d = dst_data_q;
        pkt_cnt_d  = pkt_cnt_q;

        if (!cfg_en) begin
            // Disable discards any partial packet; pkt_cnt is retained.
            state_d    = ST_DATA;
            byte_cnt_d = '0;
            csum_d     = '0;
            dst_val_d  = 1'b0;
            dst_last_d = 1'b0;
            dst_data_d = '0;
        end else begin
            unique case (state_q)
                ST_DATA: begin
                    if (acc) begin
                        dst_data_d = src_data;
                        dst_val_d  = 1'b1;
                        dst_last_d = 1'b0;
                        csum_d     = csum_q + src_data;
                        if (byte_cnt_q == CNT_W'(PKT_LEN - 1)) begin
                            byte_cnt_d = '0;
                            state_d    = ST_CSUM;
                        end else begin
                            byte_cnt_d = byte_cnt_q + 1'b1;
                        end
                    end else if (dst_rdy && dst_val_q) begin
                        dst_val_d = 1'b0;
                    end
                end
                ST_CSUM: begin
                    if (slot_free) begin
                        dst_data_d = (~csum_q) + 8'd1;
                        dst_val_d  = 1'b1;
                        dst_last_d = 1'b1;
                        csum_d     = '0;
                        state_d    = ST_DATA;
                    end
                end
                default: state_d = ST_DATA;
            endcase

            if (dst_val_q && dst_rdy && dst_last_q) begin
                pkt_cnt_d = pkt_cnt_q + 16'd1;
            end
        end
    end

    // State register with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_DATA;
            byte_cnt_q <= '0;
            csum_q     <= '0;
            dst_val_q  <= 1'b0;
            dst_last_q <= 1'b0;
            dst_data_q <= '0;
            pkt_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            csum_q     <= csum_d;
            dst_val_q  <= dst_val_d;
            dst_last_q <= dst_last_d;
            dst_data_q <= dst_data_d;
            pkt_cnt_q  <= pkt_cnt_d;
        end
    end

    // Output drive straight from flops.
    always_comb begin
        dst_val  = dst_val_q;
        dst_last = dst_last_q;
        dst_data = dst_data_q;
        pkt_cnt  = pkt_cnt_q;
    end

endmodule
